// File: rtl/scratchpad_fprint_pkg.sv
// scratchpad_fprint_pkg: shared widths, CRC constants, FIFO entry type and single-cycle CRC step.
package scratchpad_fprint_pkg;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;
  localparam int BE_W = 4;
  localparam int WORD_W = BE_W + ADDR_W + DATA_W;
  localparam logic [31:0] CRC_POLY = 32'h04C1_1DB7;
  localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
  typedef struct packed {
    logic [31:0] crc;
    logic [7:0] seq;
  } fp_entry_t;
  function automatic logic [31:0] crc32_next48(input logic [31:0] c, input logic [WORD_W-1:0] d);
    logic [31:0] r;
    r = c;
    for (int i = WORD_W - 1; i >= 0; i--)
      r = {r[30:0], 1'b0} ^ ((r[31] ^ d[i]) ? CRC_POLY : 32'h0);
    return r;
  endfunction
endpackage

// File: rtl/scratchpad_write_fprint_if.sv
// scratchpad_write_fprint_if: scratchpad bus tap plus fingerprint output stream.
interface scratchpad_write_fprint_if;
  import scratchpad_fprint_pkg::*;
  logic [ADDR_W-1:0] address;
  logic [BE_W-1:0] byteenable;
  logic chipselect;
  logic write;
  logic [DATA_W-1:0] writedata;
  logic clken;
  logic reset_req;
  logic fp_valid;
  logic fp_ready;
  logic [31:0] fp_data;
  logic [7:0] fp_seq;
  modport master (
    output address, byteenable, chipselect, write, writedata, clken, reset_req, fp_ready,
    input fp_valid, fp_data, fp_seq
  );
  modport slave (
    input address, byteenable, chipselect, write, writedata, clken, reset_req, fp_ready,
    output fp_valid, fp_data, fp_seq
  );
endinterface

// File: rtl/scratchpad_write_fprint_fifo.sv
// fprint_fifo: first-word-fall-through FIFO of fingerprint entries; push while full succeeds only with a same-cycle pop.
module fprint_fifo
  import scratchpad_fprint_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  logic      pop,
  input  fp_entry_t din,
  output fp_entry_t dout,
  output logic      full,
  output logic      empty
);
  localparam int AW = $clog2(DEPTH);
  fp_entry_t mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] count;
  logic wr, rd;
  always_comb begin
    full = count == (AW+1)'(DEPTH);
    empty = count == '0;
    rd = pop && !empty;
    wr = push && (!full || rd);
    dout = empty ? '0 : mem[rp];
  end
  always_ff @(posedge clk)
    if (wr) mem[wp] <= din;
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= wp + AW'(wr);
      rp <= rp + AW'(rd);
      count <= count + (AW+1)'(wr) - (AW+1)'(rd);
    end
  end
endmodule

// File: rtl/scratchpad_write_fprint.sv
// scratchpad_write_fprint: CRC-32 fingerprints of accepted scratchpad writes, one per INTERVAL writes or flush.
module scratchpad_write_fprint
  import scratchpad_fprint_pkg::*;
#(
  parameter int INTERVAL = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  scratchpad_write_fprint_if.slave bus,
  input  logic                     fp_enable,
  input  logic                     flush,
  input  logic                     overflow_clr,
  output logic                     overflow
);
  logic [31:0] crc, crc_upd;
  logic [7:0] cnt, cnt_upd, seq;
  logic [DATA_W-1:0] masked;
  logic accept, term, push, pop, push_ok, full, empty;
  fp_entry_t head;
  always_comb begin
    masked = '0;
    for (int i = 0; i < BE_W; i++)
      masked[8*i +: 8] = bus.byteenable[i] ? bus.writedata[8*i +: 8] : 8'h00;
    accept = bus.chipselect & bus.write & bus.clken & ~bus.reset_req & fp_enable;
    crc_upd = accept ? crc32_next48(crc, {bus.byteenable, bus.address, masked}) : crc;
    cnt_upd = cnt + 8'(accept);
    term = accept && cnt_upd == 8'(INTERVAL);
    push = term || (flush && cnt_upd != 8'd0);
    pop = bus.fp_valid & bus.fp_ready;
    push_ok = push && (!full || pop);
  end
  // A dropped fingerprint still closes the interval; only the sequence number is withheld.
  always_ff @(posedge clk) begin
    if (reset) begin
      crc <= CRC_INIT;
      cnt <= 8'd0;
      seq <= 8'd0;
      overflow <= 1'b0;
    end else begin
      crc <= push ? CRC_INIT : crc_upd;
      cnt <= push ? 8'd0 : cnt_upd;
      seq <= seq + 8'(push_ok);
      overflow <= (push && !push_ok) || (overflow && !overflow_clr);
    end
  end
  fprint_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk  (clk),
    .rst  (reset),
    .push (push_ok),
    .pop  (pop),
    .din  ('{crc: crc_upd, seq: seq}),
    .dout (head),
    .full (full),
    .empty(empty)
  );
  assign bus.fp_valid = !empty;
  assign bus.fp_data = head.crc;
  assign bus.fp_seq = head.seq;
endmodule

// File: doc/scratchpad_write_fprint.md
SCRATCHPAD_WRITE_FPRINT -- requirements
Module: scratchpad_write_fprint

Interface
REQ-001 Parameter INTERVAL, default 16, accepted writes per fingerprint (legal 1..255).
REQ-002 Parameter FIFO_DEPTH, default 4, fingerprint output FIFO entries (power of two, 2..16).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 address  input  12  scratchpad word address, tapped from the scratchpad slave bus.
REQ-006 byteenable  input  4  scratchpad byte enables.
REQ-007 chipselect  input  1  scratchpad chipselect.
REQ-008 write  input  1  scratchpad write strobe.
REQ-009 writedata  input  32  scratchpad write data.
REQ-010 clken  input  1  scratchpad clock enable.
REQ-011 reset_req  input  1  scratchpad reset request; suppresses capture while high.
REQ-012 fp_enable  input  1  capture enable; level.
REQ-013 flush  input  1  one-cycle pulse; close the current interval early.
REQ-014 overflow_clr  input  1  one-cycle pulse; clears overflow.
REQ-015 fp_valid  output  1  FIFO head valid.
REQ-016 fp_ready  input  1  consumer accepts head when high with fp_valid.
REQ-017 fp_data  output  32  fingerprint CRC at FIFO head.
REQ-018 fp_seq  output  8  sequence number at FIFO head.
REQ-019 overflow  output  1  sticky: a fingerprint was dropped.

Function
REQ-020 Accepted write = chipselect & write & clken & ~reset_req & fp_enable in one cycle.
REQ-021 Per accepted write, CRC input word is 48 bits {byteenable, address, masked_data}, MSB first; masked_data zeroes each byte whose byteenable bit is 0.
REQ-022 CRC-32, polynomial 0x04C11DB7, init 0xFFFFFFFF, non-reflected, no final XOR; all 48 bits folded in one cycle.
REQ-023 Write counter (8 bit) increments per accepted write; on reaching INTERVAL the post-update CRC is pushed, CRC reloads init, counter clears, same edge.
REQ-024 Latency: write accepted in cycle N -> entry visible on fp_valid/fp_data in cycle N+1 (FIFO empty before).
REQ-025 flush with counter > 0 pushes current CRC (including a same-cycle accepted write) and reinitialises; flush with counter 0 and no same-cycle write does nothing.
REQ-026 flush coinciding with the terminal write produces exactly one push.
REQ-027 fp_seq: 8-bit counter, value stored with each successful push, increments only on successful push, wraps 255->0.
REQ-028 FIFO first-word-fall-through; pop when fp_valid & fp_ready; fp_data/fp_seq hold while fp_valid & ~fp_ready.
REQ-029 Push when FIFO full and no same-cycle pop: entry dropped, overflow set, fp_seq unchanged, CRC/counter still reinitialise.
REQ-030 Push and pop in same cycle while full: both succeed, occupancy unchanged, no overflow.
REQ-031 overflow_clr clears overflow; a same-cycle drop wins (overflow stays 1).
REQ-032 fp_enable low: no captures; CRC, counter and FIFO retained; flush still honoured.
REQ-033 reset_req high does not clear state; only suppresses capture.

Reset
REQ-034 reset: CRC=0xFFFFFFFF, write counter=0, fp_seq counter=0, FIFO empty, fp_valid=0, fp_data=0, fp_seq=0, overflow=0.
REQ-035 reset mid-interval discards partial CRC and all FIFO contents; first accepted write after release begins a new interval.

Structure
REQ-036 Shared package scratchpad_fprint_pkg holds CRC polynomial, init constant, address/data/byteenable widths, and the 48-bit single-cycle CRC next-state function.
REQ-037 FIFO is one sub-module, fprint_fifo (32+8 bit entries, FIFO_DEPTH, FWFT, full/empty flags); counters and CRC reside in the top.

Verification
REQ-038 INTERVAL=4, fp_ready=1, 4 writes addr 0x000..0x003 data 0x11111111, be 0xF -> one fp_valid pulse cycle after 4th write, fp_seq=0, fp_data equals package-function model.
REQ-039 Write addr 0x010 data 0xAABBCCDD be 0x3 -> CRC computed over masked data 0x0000CCDD; a changed upper byte with be 0x3 gives identical fp_data.
REQ-040 INTERVAL=16, 3 writes then flush -> one entry fp_seq=0; immediate second flush -> no entry.
REQ-041 FIFO_DEPTH=4, INTERVAL=1, fp_ready=0, 5 writes -> 4 entries fp_seq 0..3, overflow=1; fp_ready=1 drains 0..3 in order; overflow_clr -> 0.
REQ-042 Full FIFO, fp_ready=1 and terminal write same cycle -> no overflow, new entry fp_seq=4 at tail.
REQ-043 reset asserted after 2 of 4 writes with 1 entry queued -> fp_valid=0, overflow=0; next 4 writes yield fp_seq=0, CRC from init.
